// File: rtl/conv_tile_scheduler.sv
// Tile sequencer for the convolution accelerator.
// Walks the rc/n/m tile loop nest and hands each tile to the load, conv and store engines in turn.
module conv_tile_scheduler #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sched_start,
    output logic          sched_done,
    output logic          sched_busy,
    input  logic [CW-1:0] cfg_m_tiles,
    input  logic [CW-1:0] cfg_n_tiles,
    input  logic [CW-1:0] cfg_rc_tiles,
    output logic          load_start,
    input  logic          load_done,
    output logic          conv_start,
    input  logic          conv_done,
    output logic          acc_first,
    output logic          store_start,
    input  logic          store_done,
    output logic [CW-1:0] tile_m,
    output logic [CW-1:0] tile_n,
    output logic [CW-1:0] tile_rc
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_WAIT,
        S_CONV,
        S_CONV_WAIT,
        S_STORE,
        S_STORE_WAIT,
        S_DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cfg_m;
    logic [CW-1:0] cfg_n;
    logic [CW-1:0] cfg_rc;
    logic [CW-1:0] m_last;
    logic [CW-1:0] n_last;
    logic [CW-1:0] rc_last;
    logic          cfg_has_zero;

    // Loop bounds compare against count-1 so an all-ones count never needs a wider counter.
    assign m_last       = cfg_m  - CW'(1);
    assign n_last       = cfg_n  - CW'(1);
    assign rc_last      = cfg_rc - CW'(1);
    assign cfg_has_zero = (cfg_m_tiles == '0) || (cfg_n_tiles == '0) || (cfg_rc_tiles == '0);

    // NOTE: reset is synchronous and active-low; every register here is state, so all use <=.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            cfg_m   <= '0;
            cfg_n   <= '0;
            cfg_rc  <= '0;
            tile_m  <= '0;
            tile_n  <= '0;
            tile_rc <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (sched_start) begin
                        cfg_m   <= cfg_m_tiles;
                        cfg_n   <= cfg_n_tiles;
                        cfg_rc  <= cfg_rc_tiles;
                        tile_m  <= '0;
                        tile_n  <= '0;
                        tile_rc <= '0;
                        state   <= cfg_has_zero ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: state <= S_LOAD_WAIT;
                S_LOAD_WAIT: begin
                    if (load_done) state <= S_CONV;
                end
                S_CONV: state <= S_CONV_WAIT;
                S_CONV_WAIT: begin
                    if (conv_done) begin
                        if (tile_m < m_last) begin
                            tile_m <= tile_m + CW'(1);
                            state  <= S_LOAD;
                        end else begin
                            state  <= S_STORE;
                        end
                    end
                end
                S_STORE: state <= S_STORE_WAIT;
                S_STORE_WAIT: begin
                    if (store_done) begin
                        tile_m <= '0;
                        if (tile_n < n_last) begin
                            tile_n <= tile_n + CW'(1);
                            state  <= S_LOAD;
                        end else if (tile_rc < rc_last) begin
                            tile_n  <= '0;
                            tile_rc <= tile_rc + CW'(1);
                            state   <= S_LOAD;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes decode straight from the state register, so each lasts exactly one cycle.
    assign load_start  = (state == S_LOAD);
    assign conv_start  = (state == S_CONV);
    assign store_start = (state == S_STORE);
    assign sched_done  = (state == S_DONE);
    assign sched_busy  = (state != S_IDLE);
    assign acc_first   = ((state == S_CONV) || (state == S_CONV_WAIT)) && (tile_m == '0);

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler: tile order, strobe counts, ignored dones, mid-layer reset,
// and a narrow CW=4 instance running the full 15-tile inner loop.
module tb_conv_tile_scheduler;

    localparam int CW  = 8;
    localparam int CW2 = 4;

    typedef struct packed {
        logic [7:0] rc;
        logic [7:0] n;
        logic [7:0] m;
        logic       acc;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          sched_start;
    logic          sched_done;
    logic          sched_busy;
    logic [CW-1:0] cfg_m;
    logic [CW-1:0] cfg_n;
    logic [CW-1:0] cfg_rc;
    logic          load_start;
    logic          load_done;
    logic          conv_start;
    logic          conv_done;
    logic          acc_first;
    logic          store_start;
    logic          store_done;
    logic [CW-1:0] tile_m;
    logic [CW-1:0] tile_n;
    logic [CW-1:0] tile_rc;

    logic [2:0] auto_done = '0;
    logic [2:0] man_done  = '0;
    logic       auto_en   = 1'b1;
    int         resp_dly  = 3;
    int         resp_cnt [3] = '{0, 0, 0};

    assign load_done  = auto_done[0] | man_done[0];
    assign conv_done  = auto_done[1] | man_done[1];
    assign store_done = auto_done[2] | man_done[2];

    conv_tile_scheduler #(.CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sched_start (sched_start),
        .sched_done  (sched_done),
        .sched_busy  (sched_busy),
        .cfg_m_tiles (cfg_m),
        .cfg_n_tiles (cfg_n),
        .cfg_rc_tiles(cfg_rc),
        .load_start  (load_start),
        .load_done   (load_done),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .acc_first   (acc_first),
        .store_start (store_start),
        .store_done  (store_done),
        .tile_m      (tile_m),
        .tile_n      (tile_n),
        .tile_rc     (tile_rc)
    );

    // Narrow instance: engines always answer 2 cycles after each start.
    logic           d2_start;
    logic           d2_done;
    logic           d2_busy;
    logic [CW2-1:0] d2_cfg_m;
    logic [CW2-1:0] d2_cfg_n;
    logic [CW2-1:0] d2_cfg_rc;
    logic           d2_load_start;
    logic           d2_conv_start;
    logic           d2_store_start;
    logic           d2_acc_first;
    logic [2:0]     d2_auto_done = '0;
    int             d2_cnt [3] = '{0, 0, 0};
    logic [CW2-1:0] d2_tile_m;
    logic [CW2-1:0] d2_tile_n;
    logic [CW2-1:0] d2_tile_rc;

    conv_tile_scheduler #(.CW(CW2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .sched_start (d2_start),
        .sched_done  (d2_done),
        .sched_busy  (d2_busy),
        .cfg_m_tiles (d2_cfg_m),
        .cfg_n_tiles (d2_cfg_n),
        .cfg_rc_tiles(d2_cfg_rc),
        .load_start  (d2_load_start),
        .load_done   (d2_auto_done[0]),
        .conv_start  (d2_conv_start),
        .conv_done   (d2_auto_done[1]),
        .acc_first   (d2_acc_first),
        .store_start (d2_store_start),
        .store_done  (d2_auto_done[2]),
        .tile_m      (d2_tile_m),
        .tile_n      (d2_tile_n),
        .tile_rc     (d2_tile_rc)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Engine models: a start seen at a falling edge yields a one-cycle done resp_dly cycles later.
    always @(negedge clk) begin : responder
        logic [2:0] st;
        logic [2:0] st2;
        st  = {store_start, conv_start, load_start};
        st2 = {d2_store_start, d2_conv_start, d2_load_start};
        for (int e = 0; e < 3; e++) begin
            auto_done[e] = 1'b0;
            if (st[e] && auto_en) resp_cnt[e] = resp_dly;
            else if (resp_cnt[e] > 0) begin
                resp_cnt[e]--;
                if (resp_cnt[e] == 0) auto_done[e] = 1'b1;
            end
            d2_auto_done[e] = 1'b0;
            if (st2[e]) d2_cnt[e] = 2;
            else if (d2_cnt[e] > 0) begin
                d2_cnt[e]--;
                if (d2_cnt[e] == 0) d2_auto_done[e] = 1'b1;
            end
        end
    end

    rec_t load_q[$];
    rec_t conv_q[$];
    rec_t store_q[$];
    int   done_pulses = 0;

    int             d2_loads   = 0;
    int             d2_convs   = 0;
    int             d2_stores  = 0;
    int             d2_seq_err = 0;
    logic [CW2-1:0] d2_max_m   = '0;
    logic [CW2-1:0] d2_store_m = '0;

    always @(negedge clk) begin
        if (load_start)  load_q.push_back('{rc: tile_rc, n: tile_n, m: tile_m, acc: acc_first});
        if (conv_start)  conv_q.push_back('{rc: tile_rc, n: tile_n, m: tile_m, acc: acc_first});
        if (store_start) store_q.push_back('{rc: tile_rc, n: tile_n, m: tile_m, acc: acc_first});
        if (sched_done)  done_pulses++;
        if (d2_load_start) d2_loads++;
        if (d2_conv_start) begin
            if (d2_tile_m != CW2'(d2_convs)) d2_seq_err++;
            if (d2_tile_m > d2_max_m) d2_max_m = d2_tile_m;
            d2_convs++;
        end
        if (d2_store_start) begin
            d2_stores++;
            d2_store_m = d2_tile_m;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        load_q.delete();
        conv_q.delete();
        store_q.delete();
        done_pulses = 0;
    endtask

    // Returns on the falling edge right after the accepted start.
    task automatic start_layer(input int m, input int n, input int rc);
        @(negedge clk);
        cfg_m       = 8'(m);
        cfg_n       = 8'(n);
        cfg_rc      = 8'(rc);
        sched_start = 1'b1;
        @(negedge clk);
        sched_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (sched_done) seen = 1'b1;
            else @(negedge clk);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({tag, "_idle_after"}, {30'd0, sched_busy, sched_done}, 32'd0);
    endtask

    task automatic pulse_done(input int idx, input int cycles);
        @(negedge clk);
        man_done[idx] = 1'b1;
        repeat (cycles) @(negedge clk);
        man_done[idx] = 1'b0;
    endtask

    // Full layer with auto-responding engines; expected order comes from the bench's own loop nest.
    task automatic run_layer(input string tag, input int m, input int n, input int rc);
        rec_t e;
        int   i;
        int   s;
        clear_log();
        start_layer(m, n, rc);
        check({tag, "_first_load"}, 32'(load_start), 32'd1);
        wait_done(tag, 4000);
        check({tag, "_loads"},  32'(load_q.size()),  32'(m * n * rc));
        check({tag, "_convs"},  32'(conv_q.size()),  32'(m * n * rc));
        check({tag, "_stores"}, 32'(store_q.size()), 32'(n * rc));
        check({tag, "_done_pulses"}, 32'(done_pulses), 32'd1);
        i = 0;
        s = 0;
        for (int r = 0; r < rc; r++) begin
            for (int c = 0; c < n; c++) begin
                for (int k = 0; k < m; k++) begin
                    e = '{rc: 8'(r), n: 8'(c), m: 8'(k), acc: 1'b0};
                    if (i < load_q.size())
                        check($sformatf("%s_load%0d", tag, i), 32'(load_q[i]), 32'(e));
                    e.acc = (k == 0);
                    if (i < conv_q.size())
                        check($sformatf("%s_conv%0d", tag, i), 32'(conv_q[i]), 32'(e));
                    i++;
                end
                e = '{rc: 8'(r), n: 8'(c), m: 8'(m - 1), acc: 1'b0};
                if (s < store_q.size())
                    check($sformatf("%s_store%0d", tag, s), 32'(store_q[s]), 32'(e));
                s++;
            end
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        bit found;
        rst         = 1'b0;
        sched_start = 1'b0;
        cfg_m       = '0;
        cfg_n       = '0;
        cfg_rc      = '0;
        d2_start    = 1'b0;
        d2_cfg_m    = '0;
        d2_cfg_n    = '0;
        d2_cfg_rc   = '0;

        repeat (3) @(negedge clk);
        check("reset_strobes", {26'd0, sched_busy, sched_done, load_start, conv_start, store_start, acc_first}, 32'd0);
        check("reset_tiles", {8'd0, tile_rc, tile_n, tile_m}, 32'd0);
        check("reset_d2", {25'd0, d2_busy, d2_done, d2_tile_m}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single tile, engines answer 3 cycles after their start.
        resp_dly = 3;
        run_layer("t1", 1, 1, 1);

        // 3x2x2 loop nest.
        run_layer("t2", 3, 2, 2);

        // Zero count: DONE straight from IDLE, no engine traffic.
        clear_log();
        start_layer(2, 0, 2);
        check("t3_done_next_cycle", 32'(sched_done), 32'd1);
        check("t3_busy_in_done", 32'(sched_busy), 32'd1);
        repeat (4) @(negedge clk);
        check("t3_engine_pulses", 32'(load_q.size() + conv_q.size() + store_q.size()), 32'd0);
        check("t3_done_pulses", 32'(done_pulses), 32'd1);
        check("t3_busy_after", 32'(sched_busy), 32'd0);

        // Manual engines: spurious/held dones and a re-pulsed start must all be ignored.
        auto_en = 1'b0;
        clear_log();
        start_layer(2, 1, 1);
        @(negedge clk);
        man_done[1] = 1'b1;
        sched_start = 1'b1;
        @(negedge clk);
        man_done[1] = 1'b0;
        sched_start = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_no_conv_on_spurious", 32'(conv_q.size()), 32'd0);
        check("t4_restart_ignored", 32'(load_q.size()), 32'd1);
        pulse_done(0, 4);
        check("t4_held_load_once", 32'(conv_q.size()), 32'd1);
        repeat (2) @(negedge clk);
        pulse_done(1, 1);
        repeat (2) @(negedge clk);
        check("t4_second_load", 32'(load_q.size()), 32'd2);
        check("t4_tile_m", 32'(tile_m), 32'd1);
        pulse_done(0, 1);
        repeat (2) @(negedge clk);
        pulse_done(1, 1);
        repeat (2) @(negedge clk);
        pulse_done(2, 1);
        wait_done("t4", 20);
        check("t4_convs", 32'(conv_q.size()), 32'd2);
        check("t4_stores", 32'(store_q.size()), 32'd1);

        // Reset while waiting on the conv of tile (0,1,1); the pending conv_done lands in IDLE.
        auto_en  = 1'b1;
        resp_dly = 5;
        clear_log();
        start_layer(2, 2, 1);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (conv_start && tile_n == 8'd1 && tile_m == 8'd1) found = 1'b1;
        end
        check("t5_reached_011", 32'(found), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("t5_reset_strobes", {26'd0, sched_busy, sched_done, load_start, conv_start, store_start, acc_first}, 32'd0);
        check("t5_reset_tiles", {8'd0, tile_rc, tile_n, tile_m}, 32'd0);
        repeat (6) @(negedge clk);
        check("t5_late_done_ignored", {31'd0, sched_busy}, 32'd0);
        check("t5_convs_before_reset", 32'(conv_q.size()), 32'd4);
        check("t5_no_done", 32'(done_pulses), 32'd0);
        resp_dly = 3;
        run_layer("t5r", 1, 1, 1);

        // CW=4 with an all-ones inner count.
        @(negedge clk);
        d2_cfg_m  = 4'd15;
        d2_cfg_n  = 4'd1;
        d2_cfg_rc = 4'd1;
        d2_start  = 1'b1;
        @(negedge clk);
        d2_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (d2_done) found = 1'b1;
            else @(negedge clk);
        end
        check("t6_done_seen", 32'(found), 32'd1);
        @(negedge clk);
        check("t6_loads", 32'(d2_loads), 32'd15);
        check("t6_convs", 32'(d2_convs), 32'd15);
        check("t6_stores", 32'(d2_stores), 32'd1);
        check("t6_max_m", 32'(d2_max_m), 32'd14);
        check("t6_store_m", 32'(d2_store_m), 32'd14);
        check("t6_m_sequence", 32'(d2_seq_err), 32'd0);
        check("t6_busy_after", 32'(d2_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
